// File: rtl/instr_sequencer.sv
// Program RAM plus in-order instruction issue over a valid/ready handshake.
// Optional build macro SEQ_LOOP_EN adds a 'loop' input that restarts the program at pc=0 instead of finishing.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  input  logic          instr_ready,
`ifdef SEQ_LOOP_EN
  input  logic          loop,
`endif
  output logic [15:0]   instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  // Handshake: a word transfers on any cycle where instr_valid && instr_ready;
  // while instr_ready is low the presented word, pc and instr_valid hold.
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [AW:0]   r_len;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_instr;
  logic          r_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_loop;

  logic [AW:0]   w_len;
  logic          w_last;
  logic [AW-1:0] w_pc_next;
  logic          w_loop_in;

  assign w_len     = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign w_last    = ({1'b0, r_pc} == (r_len - 1'b1));
  assign w_pc_next = r_pc + 1'b1;

`ifdef SEQ_LOOP_EN
  assign w_loop_in = loop;
`else
  assign w_loop_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (load_en && (r_state == S_IDLE)) r_mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_loop  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (prog_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_len   <= w_len;
              r_loop  <= w_loop_in;
              r_pc    <= '0;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              // Same-cycle write to word 0 must be visible in the first issued word.
              r_instr <= (load_en && (load_addr == '0)) ? load_data : r_mem[0];
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_busy  <= 1'b0;
          end else if (instr_ready) begin
            if (!w_last) begin
              r_pc    <= w_pc_next;
              r_instr <= r_mem[w_pc_next];
            end else if (r_loop) begin
              r_pc    <= '0;
              r_instr <= r_mem[0];
            end else begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_instr <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table for the main flows plus
// hand-written sequences for async reset, length clamping and optional looping.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        abort;
  logic        instr_ready;
`ifdef SEQ_LOOP_EN
  logic        loop;
`endif
  logic [15:0] instruction;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  instr_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .abort(abort), .instr_ready(instr_ready),
`ifdef SEQ_LOOP_EN
    .loop(loop),
`endif
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [4:0]  len;
    logic        st;
    logic        ab;
    logic        rdy;
    logic [15:0] e_instr;
    logic        e_valid;
    logic [3:0]  e_pc;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_en = 0; load_addr = '0; load_data = '0; prog_len = '0;
    start = 0; abort = 0; instr_ready = 0;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] ei, input logic ev,
                            input logic [3:0] ep, input logic eb, input logic ed);
    check({tag, " instruction"}, 32'(instruction), 32'(ei));
    check({tag, " instr_valid"}, 32'(instr_valid), 32'(ev));
    check({tag, " pc"},          32'(pc),          32'(ep));
    check({tag, " busy"},        32'(busy),        32'(eb));
    check({tag, " done"},        32'(done),        32'(ed));
  endtask

  initial begin
    int n_xfer;
    logic got_done;

    // ld addr data len st ab rdy | instr valid pc busy done
    vecs[0]  = '{1, 4'd0, 16'h0A50, 5'd0, 0, 0, 0, 16'h0000, 0, 4'd0, 0, 0};
    vecs[1]  = '{1, 4'd1, 16'h0B61, 5'd0, 0, 0, 0, 16'h0000, 0, 4'd0, 0, 0};
    vecs[2]  = '{1, 4'd2, 16'hB562, 5'd0, 0, 0, 0, 16'h0000, 0, 4'd0, 0, 0};
    vecs[3]  = '{0, 4'd0, 16'h0000, 5'd3, 1, 0, 1, 16'h0A50, 1, 4'd0, 1, 0};
    vecs[4]  = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0B61, 1, 4'd1, 1, 0};
    vecs[5]  = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'hB562, 1, 4'd2, 1, 0};
    vecs[6]  = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0000, 0, 4'd2, 0, 1};
    vecs[7]  = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 0, 16'h0000, 0, 4'd2, 0, 0};
    // stall at pc=1 for two cycles
    vecs[8]  = '{0, 4'd0, 16'h0000, 5'd3, 1, 0, 0, 16'h0A50, 1, 4'd0, 1, 0};
    vecs[9]  = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0B61, 1, 4'd1, 1, 0};
    vecs[10] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 0, 16'h0B61, 1, 4'd1, 1, 0};
    vecs[11] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 0, 16'h0B61, 1, 4'd1, 1, 0};
    vecs[12] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'hB562, 1, 4'd2, 1, 0};
    vecs[13] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 0, 16'hB562, 1, 4'd2, 1, 0};
    vecs[14] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0000, 0, 4'd2, 0, 1};
    vecs[15] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 0, 16'h0000, 0, 4'd2, 0, 0};
    // prog_len = 0
    vecs[16] = '{0, 4'd0, 16'h0000, 5'd0, 1, 0, 1, 16'h0000, 0, 4'd2, 0, 1};
    vecs[17] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0000, 0, 4'd2, 0, 0};
    // abort at pc=1, then reload word 1 and run it
    vecs[18] = '{0, 4'd0, 16'h0000, 5'd3, 1, 0, 1, 16'h0A50, 1, 4'd0, 1, 0};
    vecs[19] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0B61, 1, 4'd1, 1, 0};
    vecs[20] = '{0, 4'd0, 16'h0000, 5'd0, 0, 1, 1, 16'h0000, 0, 4'd1, 0, 0};
    vecs[21] = '{1, 4'd1, 16'h1234, 5'd0, 0, 0, 0, 16'h0000, 0, 4'd1, 0, 0};
    vecs[22] = '{0, 4'd0, 16'h0000, 5'd2, 1, 0, 0, 16'h0A50, 1, 4'd0, 1, 0};
    vecs[23] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h1234, 1, 4'd1, 1, 0};
    vecs[24] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0000, 0, 4'd1, 0, 1};
    // load and start ignored in RUN
    vecs[25] = '{0, 4'd0, 16'h0000, 5'd3, 1, 0, 0, 16'h0A50, 1, 4'd0, 1, 0};
    vecs[26] = '{1, 4'd0, 16'hFFFF, 5'd1, 1, 0, 0, 16'h0A50, 1, 4'd0, 1, 0};
    vecs[27] = '{0, 4'd0, 16'h0000, 5'd0, 0, 1, 0, 16'h0000, 0, 4'd0, 0, 0};
    vecs[28] = '{0, 4'd0, 16'h0000, 5'd1, 1, 0, 1, 16'h0A50, 1, 4'd0, 1, 0};
    vecs[29] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0000, 0, 4'd0, 0, 1};
    // load and start together at address 0
    vecs[30] = '{1, 4'd0, 16'h0C0C, 5'd1, 1, 0, 0, 16'h0C0C, 1, 4'd0, 1, 0};
    vecs[31] = '{0, 4'd0, 16'h0000, 5'd0, 0, 0, 1, 16'h0000, 0, 4'd0, 0, 1};
    vecs[32] = '{1, 4'd0, 16'h0A50, 5'd0, 0, 0, 0, 16'h0000, 0, 4'd0, 0, 0};
    vecs[33] = '{1, 4'd1, 16'h0B61, 5'd0, 0, 0, 0, 16'h0000, 0, 4'd0, 0, 0};

    idle_inputs();
`ifdef SEQ_LOOP_EN
    loop = 0;
`endif
    rst_n = 0;
    #12;
    check_outs("reset", 16'h0, 0, 4'd0, 0, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < NV; i++) begin
      load_en = vecs[i].ld; load_addr = vecs[i].addr; load_data = vecs[i].data;
      prog_len = vecs[i].len; start = vecs[i].st; abort = vecs[i].ab;
      instr_ready = vecs[i].rdy;
      step();
      check_outs($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_valid,
                 vecs[i].e_pc, vecs[i].e_busy, vecs[i].e_done);
    end
    idle_inputs();
    step();

    // Asynchronous reset mid-RUN; RAM must survive.
    prog_len = 5'd3; start = 1; instr_ready = 1;
    step();
    start = 0;
    step();
    check_outs("pre_rst", 16'h0B61, 1, 4'd1, 1, 0);
    #3 rst_n = 0;
    #1;
    check_outs("async_rst", 16'h0, 0, 4'd0, 0, 0);
    #1 rst_n = 1;
    idle_inputs();
    step();
    prog_len = 5'd3; start = 1; instr_ready = 1;
    step();
    start = 0;
    check_outs("rerun0", 16'h0A50, 1, 4'd0, 1, 0);
    step();
    check_outs("rerun1", 16'h0B61, 1, 4'd1, 1, 0);
    step();
    check_outs("rerun2", 16'hB562, 1, 4'd2, 1, 0);
    step();
    check_outs("rerun_end", 16'h0, 0, 4'd2, 0, 1);
    idle_inputs();

    // prog_len above DEPTH clamps to 16 words.
    for (int a = 0; a < 16; a++) begin
      load_en = 1; load_addr = 4'(a); load_data = 16'hA000 + 16'(a);
      step();
    end
    load_en = 0;
    prog_len = 5'd20; start = 1; instr_ready = 1;
    step();
    start = 0;
    n_xfer = 0;
    got_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (instr_valid) begin
        check($sformatf("clamp pc %0d", n_xfer), 32'(pc), 32'(n_xfer));
        check($sformatf("clamp word %0d", n_xfer), 32'(instruction), 32'(16'hA000 + 16'(n_xfer)));
        n_xfer++;
      end else if (done) begin
        got_done = 1;
        break;
      end
      step();
    end
    check("clamp transfers", 32'(n_xfer), 32'd16);
    check("clamp done seen", 32'(got_done), 32'd1);
    idle_inputs();
    step();

`ifdef SEQ_LOOP_EN
    // Looping: pc 0,1,0,1,... with no done, abort ends it.
    loop = 1; prog_len = 5'd2; start = 1; instr_ready = 1;
    step();
    start = 0; loop = 0;
    for (int k = 0; k < 6; k++) begin
      check_outs($sformatf("loop%0d", k), 16'hA000 + 16'(k % 2), 1, 4'(k % 2), 1, 0);
      step();
    end
    abort = 1;
    step();
    abort = 0;
    check_outs("loop_abort", 16'h0, 0, 4'd0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
